mac_rx: RTL and testbench
=========================

Name: mac_rx

Overview:
- Receive-side MAC for the 10BASE-T Ethernet core. It is the counterpart of the transmit path.
- Consumes the recovered bit stream from the PLS receiver: data-valid, a one-cycle bit strobe, and a data bit.
- Hunts preamble/SFD, packs frame bits LSB-first into 32-bit words, and writes them to the RX buffer write port starting at word 1.
- Checks the CRC-32 FCS, writes a length/status header to word 0, and raises rxfull until software acknowledges.

Parameters:
- BUF_WORDS, 512, RX buffer depth in 32-bit words (word 0 = header).
- ADR_W, 9, buffer address width; must satisfy 2**ADR_W >= BUF_WORDS.
- PRE_MIN, 16, minimum alternating preamble bits before an SFD is accepted.
- MIN_BYTES, 64, frames shorter than this (FCS included) are flagged runt.

Ports:
- clk_i  in  1  MAC clock (20 MHz domain); the only clock.
- rst_ni  in  1  asynchronous active-low reset.
- rx_dv  in  1  carrier/data valid from PLS; high for the whole frame.
- rx_bit_stb  in  1  one-cycle strobe; rxd is valid in the same cycle.
- rxd  in  1  recovered data bit.
- rx_ack  in  1  one-cycle pulse from bus side: buffer consumed.
- buf_we  out  1  RX buffer write enable.
- buf_adr  out  ADR_W  RX buffer word address.
- buf_dat  out  32  RX buffer write data.
- rxfull  out  1  interrupt: frame + header in buffer.
- rx_busy  out  1  high in any state except IDLE and FULL.

Behaviour:
- Reset: all outputs 0; state IDLE; crc=32'hFFFFFFFF; bit counter 0.
- The only clock is clk_i and reset is asynchronous, active-low (rst_ni).
- IDLE:
  - rx_dv rising -> PRE; clear preamble count, flags and crc.
  - If rx_dv is already high on entry (came from FULL) -> DROP.
- PRE, on each strobe:
  - Bit equals the inverse of the previous bit -> count++.
  - Bit=1, previous=1, count>=PRE_MIN -> SFD found; go to DATA with bitcnt=0.
  - Any other pattern (00, or 11 too early) -> DROP.
  - rx_dv low -> IDLE; no write.
- DATA, on each strobe:
  - wordreg[bitcnt[4:0]]<=rxd; crc<=crc32 step (poly 04C11DB7, MSB-first shift-left form, same as TX); bitcnt++.
  - When bitcnt[4:0]==31, write: buf_we=1 for one cycle, buf_adr=1+bitcnt[13:5], buf_dat=completed word (including the current bit).
  - If that address would be >=BUF_WORDS, suppress the write and set ovf; keep counting.
- End of frame: rx_dv low in DATA -> FLUSH.
  - FLUSH writes the partial word, unfilled bits zero, only if bitcnt[4:0]!=0 and not overflowed.
  - Then HDR (one cycle) writes word 0.
  - rxfull rises the cycle after the HDR write; state FULL.
- Header word:
  - [31] crc_ok (final crc==32'hC704DD7B)
  - [30] align_err (bitcnt[2:0]!=0)
  - [29] ovf
  - [28] runt (bytes<MIN_BYTES)
  - [27:14] 0
  - [13:0] bytes=bitcnt>>3, FCS included, saturating at 14'h3FFF.
- FULL:
  - Ignores the line; no buffer writes; rxfull held.
  - rx_ack -> rxfull<=0 next cycle.
  - Then rx_dv high -> DROP, else IDLE.
- DROP: wait for rx_dv low -> IDLE; never writes, never asserts rxfull.
- Simultaneous events:
  - A strobe and rx_dv falling in the same cycle: the bit is consumed, then FLUSH.
  - rx_ack outside FULL is ignored.
- Reset mid-frame: immediate return to reset values; partially written buffer contents are undefined; no header.

Optional Feature:
- RX_ADDR_FILTER_EN defined:
  - Adds parameter MAC_ADDR (48 bits, first octet in [7:0]).
  - After bit 47 of DATA, destination is compared.
  - Accepted when: equal to MAC_ADDR, broadcast FF:FF:FF:FF:FF:FF, or group bit (bit 0) set.
  - Mismatch -> DROP: no header, no rxfull; data words 1-2 may already be written.
- Not defined: promiscuous; every frame with a valid SFD is delivered.

Test Plan:
- 64-byte frame (16-bit preamble, SFD, 60 payload bytes, correct FCS) -> words 1..16 written; header 32'h80000040; rxfull 1 cycle after HDR.
- Same frame with one payload bit flipped -> header 32'h00000040; data stored; rxfull asserted.
- Frame of 67 bytes plus 3 dribble bits -> partial word flushed at adr 17; header bits [30]=1, [13:0]=67.
- 2100-byte frame with BUF_WORDS=512 -> no write above adr 511; header ovf=1, length=2100.
- Second frame while FULL, rx_ack mid-frame -> second frame discarded, buffer unchanged; third frame received normally.
- With RX_ADDR_FILTER_EN, MAC_ADDR=02:00:00:00:00:01:
  - Frame to 02:00:00:00:00:02 -> no rxfull.
  - Frame to FF:FF:FF:FF:FF:FF -> delivered.

Source files
------------

// File: rtl/mac_rx.sv
// mac_rx: receive-side MAC for the 10BASE-T core.
// Hunts preamble/SFD in the recovered bit stream and packs frame bits LSB-first
// into 32-bit words written from word 1. It checks the CRC-32 FCS, writes a
// length/status header to word 0 and raises rxfull until software acknowledges.
//
// Optional feature: define RX_ADDR_FILTER_EN to add parameter MAC_ADDR and drop
// frames whose destination is neither MAC_ADDR, broadcast nor a group address.
// With the macro undefined the receiver is promiscuous.
//
// Handshakes: rx_bit_stb qualifies rxd for exactly one cycle (no back-pressure,
// every strobe is consumed); rx_ack is a one-cycle pulse honoured only in FULL;
// buf_we is a one-cycle write with buf_adr/buf_dat valid in the same cycle.
// The FSM state is held in 'state' (type state_t) for checkers to bind to.

module mac_rx #(
  parameter int BUF_WORDS = 512,
  parameter int ADR_W     = 9,
  parameter int PRE_MIN   = 16,
  parameter int MIN_BYTES = 64
`ifdef RX_ADDR_FILTER_EN
  ,
  parameter logic [47:0] MAC_ADDR = 48'h01_00_00_00_00_02
`endif
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rx_dv,
  input  logic             rx_bit_stb,
  input  logic             rxd,
  input  logic             rx_ack,
  output logic             buf_we,
  output logic [ADR_W-1:0] buf_adr,
  output logic [31:0]      buf_dat,
  output logic             rxfull,
  output logic             rx_busy
);

  // Bit counter is wide enough that the saturating byte count never wraps.
  localparam int BC_W = 20;
  localparam logic [15:0]     BUF_LIM = 16'(BUF_WORDS);
  localparam logic [7:0]      PRE_LIM = 8'(PRE_MIN);
  localparam logic [BC_W-4:0] MIN_B   = (BC_W-3)'(MIN_BYTES);
  localparam logic [31:0]     CRC_RESIDUE = 32'hC704DD7B;
  localparam logic [31:0]     CRC_POLY    = 32'h04C11DB7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_FLUSH,
    S_HDR,
    S_FULL,
    S_DROP
  } state_t;

  state_t state;

  logic            dv_q;
  logic [7:0]      pre_cnt;
  logic            prev_bit;
  logic            have_prev;
  logic [31:0]     crc;
  logic [BC_W-1:0] bitcnt;
  logic [31:0]     word_q;
  logic            ovf;
  logic            rxfull_pend;

  logic [31:0]     crc_next;
  logic [15:0]     wr_adr;
  logic            adr_ok;
  logic [31:0]     word_full;
  logic [BC_W-4:0] byte_cnt;
  logic [13:0]     bytes_sat;
  logic [31:0]     hdr_word;
  logic [BC_W-1:0] bitcnt_inc;
  logic [7:0]      pre_cnt_inc;

`ifdef RX_ADDR_FILTER_EN
  logic [47:0] dst_q;
  logic [47:0] dst_full;
  logic        dst_hit;
`endif

  // Datapath helpers derived from the current registers and incoming bit.
  always_comb begin
    crc_next    = {crc[30:0], 1'b0} ^ ({32{crc[31] ^ rxd}} & CRC_POLY);
    // Word address of the word currently being filled (word 0 is the header).
    wr_adr      = {1'b0, bitcnt[BC_W-1:5]} + 16'd1;
    adr_ok      = (wr_adr < BUF_LIM);
    word_full   = {rxd, word_q[30:0]};
    byte_cnt    = bitcnt[BC_W-1:3];
    bytes_sat   = (byte_cnt > (BC_W-3)'(14'h3FFF)) ? 14'h3FFF : byte_cnt[13:0];
    hdr_word    = {(crc == CRC_RESIDUE), (bitcnt[2:0] != 3'd0), ovf,
                   (byte_cnt < MIN_B), 14'd0, bytes_sat};
    bitcnt_inc  = (&bitcnt) ? bitcnt : bitcnt + 1'b1;
    pre_cnt_inc = (&pre_cnt) ? pre_cnt : pre_cnt + 8'd1;
  end

`ifdef RX_ADDR_FILTER_EN
  // Destination as it stands once bit 47 (the current bit) is consumed.
  always_comb begin
    dst_full = {rxd, dst_q[46:0]};
    dst_hit  = (dst_full == MAC_ADDR) || (&dst_full) || dst_full[0];
  end
`endif

  assign rx_busy = (state != S_IDLE) && (state != S_FULL);

  // Receive FSM with all buffer/interrupt outputs registered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= S_IDLE;
      dv_q        <= 1'b0;
      pre_cnt     <= 8'd0;
      prev_bit    <= 1'b0;
      have_prev   <= 1'b0;
      crc         <= 32'hFFFFFFFF;
      bitcnt      <= '0;
      word_q      <= 32'd0;
      ovf         <= 1'b0;
      rxfull_pend <= 1'b0;
      buf_we      <= 1'b0;
      buf_adr     <= '0;
      buf_dat     <= 32'd0;
      rxfull      <= 1'b0;
`ifdef RX_ADDR_FILTER_EN
      dst_q       <= 48'd0;
`endif
    end else begin
      dv_q   <= rx_dv;
      buf_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_dv) begin
            if (!dv_q) begin
              // Fresh carrier: start hunting the preamble.
              state     <= S_PRE;
              pre_cnt   <= 8'd0;
              have_prev <= 1'b0;
              ovf       <= 1'b0;
              crc       <= 32'hFFFFFFFF;
            end else begin
              // Carrier already up: we joined mid-frame.
              state <= S_DROP;
            end
          end
        end

        S_PRE: begin
          if (!rx_dv) begin
            state <= S_IDLE;
          end else if (rx_bit_stb) begin
            if (!have_prev) begin
              have_prev <= 1'b1;
              prev_bit  <= rxd;
              pre_cnt   <= 8'd1;
            end else if (rxd != prev_bit) begin
              prev_bit <= rxd;
              pre_cnt  <= pre_cnt_inc;
            end else if (rxd && prev_bit && (pre_cnt >= PRE_LIM)) begin
              // Closing "11" of the SFD after a long enough preamble.
              state  <= S_DATA;
              bitcnt <= '0;
              word_q <= 32'd0;
            end else begin
              state <= S_DROP;
            end
          end
        end

        S_DATA: begin
          // Carrier loss is checked together with the strobe: the last bit is
          // still consumed before flushing.
          if (!rx_dv) begin
            state <= S_FLUSH;
          end
          if (rx_bit_stb) begin
            word_q[bitcnt[4:0]] <= rxd;
            crc    <= crc_next;
            bitcnt <= bitcnt_inc;
            if (bitcnt[4:0] == 5'd31) begin
              word_q <= 32'd0;
              if (adr_ok) begin
                buf_we  <= 1'b1;
                buf_adr <= wr_adr[ADR_W-1:0];
                buf_dat <= word_full;
              end else begin
                ovf <= 1'b1;
              end
            end
`ifdef RX_ADDR_FILTER_EN
            if (bitcnt < BC_W'(48)) begin
              dst_q[bitcnt[5:0]] <= rxd;
            end
            if ((bitcnt == BC_W'(47)) && !dst_hit) begin
              state <= S_DROP;
            end
`endif
          end
        end

        S_FLUSH: begin
          // Partial last word; bits not received are already zero.
          if ((bitcnt[4:0] != 5'd0) && !ovf) begin
            if (adr_ok) begin
              buf_we  <= 1'b1;
              buf_adr <= wr_adr[ADR_W-1:0];
              buf_dat <= word_q;
            end else begin
              ovf <= 1'b1;
            end
          end
          state <= S_HDR;
        end

        S_HDR: begin
          buf_we      <= 1'b1;
          buf_adr     <= '0;
          buf_dat     <= hdr_word;
          rxfull_pend <= 1'b1;
          state       <= S_FULL;
        end

        S_FULL: begin
          if (rxfull_pend) begin
            // Interrupt follows the header write by one cycle.
            rxfull      <= 1'b1;
            rxfull_pend <= 1'b0;
          end else if (rxfull) begin
            if (rx_ack) begin
              rxfull <= 1'b0;
            end
          end else begin
            state <= rx_dv ? S_DROP : S_IDLE;
          end
        end

        S_DROP: begin
          if (!rx_dv) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_rx.sv
// tb_mac_rx: bench for mac_rx. Frames are generated with a real FCS, the
// expected buffer writes (data words then header) are queued when a frame is
// built and compared as the DUT writes the buffer.

module tb_mac_rx;

  localparam int ADR_W     = 9;
  localparam int BUF_WORDS = 512;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             rx_dv;
  logic             rx_bit_stb;
  logic             rxd;
  logic             rx_ack;
  logic             buf_we;
  logic [ADR_W-1:0] buf_adr;
  logic [31:0]      buf_dat;
  logic             rxfull;
  logic             rx_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int hdr_cyc  = -1;

  logic [ADR_W+31:0] exp_q[$];
  bit                fbits[$];

  // ---------------- clock / reset ----------------
  always #25 clk = ~clk;

`ifdef RX_ADDR_FILTER_EN
  mac_rx #(.BUF_WORDS(BUF_WORDS), .ADR_W(ADR_W), .PRE_MIN(16), .MIN_BYTES(64),
           .MAC_ADDR(48'h01_00_00_00_00_02)) dut (
`else
  mac_rx #(.BUF_WORDS(BUF_WORDS), .ADR_W(ADR_W), .PRE_MIN(16), .MIN_BYTES(64)) dut (
`endif
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .rx_dv     (rx_dv),
    .rx_bit_stb(rx_bit_stb),
    .rxd       (rxd),
    .rx_ack    (rx_ack),
    .buf_we    (buf_we),
    .buf_adr   (buf_adr),
    .buf_dat   (buf_dat),
    .rxfull    (rxfull),
    .rx_busy   (rx_busy)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input bit b);
    logic fb;
    fb = c[31] ^ b;
    return {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
  endfunction

  function automatic bit model_crc_ok();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (fbits[i]) c = crc_step(c, fbits[i]);
    return (c == 32'hC704DD7B);
  endfunction

  // Scoreboard side: every buffer write must match the head of exp_q.
  always @(negedge clk) begin
    cyc++;
    if (rst_n && buf_we) begin
      if (exp_q.size() == 0) begin
        check("write_with_empty_queue", 64'(exp_q.size()), 64'd1);
      end else begin
        check("buf_write", {buf_adr, buf_dat}, exp_q.pop_front());
        if (buf_adr == '0) begin
          hdr_cyc = cyc;
          check("rxfull_before_hdr", rxfull, 1'b0);
        end
      end
    end
    if (hdr_cyc >= 0 && cyc == hdr_cyc + 1) check("rxfull_rise", rxfull, 1'b1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  // Frame bits: dst, random payload, FCS, optional flip, optional dribble bits.
  task automatic build_frame(input int payload, input logic [47:0] dst,
                             input bit flip, input int dribble);
    logic [31:0] c;
    logic [7:0]  b;
    int          idx;
    fbits.delete();
    c = 32'hFFFFFFFF;
    for (int j = 0; j < payload; j++) begin
      b = (j < 6) ? dst[8*j +: 8] : 8'($urandom_range(0, 255));
      for (int k = 0; k < 8; k++) begin
        fbits.push_back(b[k]);
        c = crc_step(c, b[k]);
      end
    end
    for (int i = 31; i >= 0; i--) fbits.push_back(~c[i]);
    if (flip) begin
      idx = $urandom_range(48, payload * 8 - 1);
      fbits[idx] = ~fbits[idx];
    end
    for (int i = 0; i < dribble; i++) fbits.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic push_exp(input bit crc_ok);
    int          n;
    int          adr;
    int          bytes;
    bit          ovf;
    logic [31:0] w;
    logic [31:0] hdr;
    n   = fbits.size();
    w   = '0;
    ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      w[i % 32] = fbits[i];
      if (i % 32 == 31) begin
        adr = i / 32 + 1;
        if (adr < BUF_WORDS) exp_q.push_back({ADR_W'(adr), w});
        else ovf = 1'b1;
        w = '0;
      end
    end
    if ((n % 32 != 0) && !ovf) begin
      adr = n / 32 + 1;
      if (adr < BUF_WORDS) exp_q.push_back({ADR_W'(adr), w});
      else ovf = 1'b1;
    end
    bytes = n / 8;
    hdr = {crc_ok, (n % 8 != 0), ovf, (bytes < 64), 14'd0,
           (bytes > 16383) ? 14'h3FFF : 14'(bytes)};
    exp_q.push_back({ADR_W'(0), hdr});
  endtask

  // Drive preamble, SFD and fbits. dv_last drops rx_dv with the last strobe;
  // ack_at pulses rx_ack after that bit index; busy/full checked at 1/4 point.
  task automatic send_frame(input int pre_len, input bit dv_last, input int ack_at,
                            input bit busy_exp, input bit full_exp);
    bit          line[$];
    logic [7:0]  sfd;
    int          mid;
    sfd = 8'b1101_0101;
    for (int i = 0; i < pre_len; i++) line.push_back(i % 2 == 0);
    for (int k = 0; k < 8; k++) line.push_back(sfd[k]);
    foreach (fbits[i]) line.push_back(fbits[i]);
    mid = line.size() / 4;
    rx_dv = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < line.size(); i++) begin
      rxd = line[i];
      rx_bit_stb = 1'b1;
      if (dv_last && i == line.size() - 1) rx_dv = 1'b0;
      tick();
      rx_bit_stb = 1'b0;
      if (i == mid) begin
        check("busy_mid_frame", rx_busy, busy_exp);
        check("rxfull_mid_frame", rxfull, full_exp);
      end
      if (i == ack_at) begin
        rx_ack = 1'b1;
        tick();
        rx_ack = 1'b0;
      end else begin
        repeat (($urandom_range(0, 3) == 0) ? 2 : 1) tick();
      end
    end
    rx_dv = 1'b0;
    tick();
  endtask

  task automatic wait_rxfull(input string tag);
    int n;
    n = 0;
    while (!rxfull && n < 400) begin
      tick();
      n++;
    end
    check(tag, rxfull, 1'b1);
    check({tag, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    tick();
    rx_ack = 1'b0;
    repeat (3) tick();
    check("rxfull_cleared", rxfull, 1'b0);
    check("idle_after_ack", rx_busy, 1'b0);
  endtask

  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    rx_dv = 1'b0;
    rx_bit_stb = 1'b0;
    rxd = 1'b0;
    rx_ack = 1'b0;
    repeat (3) tick();
    check("reset_buf_we", buf_we, 1'b0);
    check("reset_buf_adr", buf_adr, '0);
    check("reset_buf_dat", buf_dat, 32'd0);
    check("reset_rxfull", rxfull, 1'b0);
    check("reset_rx_busy", rx_busy, 1'b0);
    rst_n = 1'b1;
    repeat (2) tick();

    // 64-byte frame with good FCS -> header 80000040
    build_frame(60, BCAST, 1'b0, 0);
    push_exp(1'b1);
    send_frame(16, 1'b0, -1, 1'b1, 1'b0);
    wait_rxfull("good64");
    do_ack();

    // Same size, one payload bit flipped -> header 00000040
    build_frame(60, BCAST, 1'b1, 0);
    push_exp(1'b0);
    send_frame(16, 1'b0, -1, 1'b1, 1'b0);
    wait_rxfull("bad_crc64");
    do_ack();

    // 67 bytes + 3 dribble bits, carrier drops with the last strobe
    build_frame(63, BCAST, 1'b0, 3);
    push_exp(model_crc_ok());
    send_frame(16, 1'b1, -1, 1'b1, 1'b0);
    wait_rxfull("dribble67");
    do_ack();

    // Runt: 20 bytes with good FCS -> header 90000014
    build_frame(16, BCAST, 1'b0, 0);
    push_exp(1'b1);
    send_frame(16, 1'b0, -1, 1'b1, 1'b0);
    wait_rxfull("runt20");
    do_ack();

    // Preamble too short -> dropped, nothing written
    build_frame(60, BCAST, 1'b0, 0);
    send_frame(4, 1'b0, -1, 1'b1, 1'b0);
    repeat (50) tick();
    check("short_pre_no_rxfull", rxfull, 1'b0);

    // 2100-byte frame overflows a 512-word buffer -> header A0000834
    build_frame(2096, BCAST, 1'b0, 0);
    push_exp(1'b1);
    send_frame(16, 1'b0, -1, 1'b1, 1'b0);
    wait_rxfull("ovf2100");
    do_ack();

    // Frame A received, frame B arrives while FULL with ack mid-frame, frame C ok
    build_frame(60, BCAST, 1'b0, 0);
    push_exp(1'b1);
    send_frame(16, 1'b0, -1, 1'b1, 1'b0);
    wait_rxfull("frame_a");
    build_frame(60, BCAST, 1'b0, 0);
    send_frame(16, 1'b0, 300, 1'b0, 1'b1);
    repeat (20) tick();
    check("frame_b_discarded", rxfull, 1'b0);
    build_frame(60, BCAST, 1'b0, 0);
    push_exp(1'b1);
    send_frame(16, 1'b0, -1, 1'b1, 1'b0);
    wait_rxfull("frame_c");
    do_ack();

    // Unicast to a foreign address
    build_frame(60, 48'h02_00_00_00_00_02, 1'b0, 0);
`ifdef RX_ADDR_FILTER_EN
    exp_q.push_back({ADR_W'(1), fbits[31], fbits[30], fbits[29], fbits[28],
                     fbits[27], fbits[26], fbits[25], fbits[24], fbits[23],
                     fbits[22], fbits[21], fbits[20], fbits[19], fbits[18],
                     fbits[17], fbits[16], fbits[15], fbits[14], fbits[13],
                     fbits[12], fbits[11], fbits[10], fbits[9], fbits[8],
                     fbits[7], fbits[6], fbits[5], fbits[4], fbits[3],
                     fbits[2], fbits[1], fbits[0]});
    send_frame(16, 1'b0, -1, 1'b1, 1'b0);
    repeat (50) tick();
    check("filter_reject_no_rxfull", rxfull, 1'b0);
    check("filter_reject_queue", 64'(exp_q.size()), 64'd0);
    // Broadcast is always accepted
    build_frame(60, BCAST, 1'b0, 0);
    push_exp(1'b1);
    send_frame(16, 1'b0, -1, 1'b1, 1'b0);
    wait_rxfull("filter_bcast");
    do_ack();
`else
    push_exp(1'b1);
    send_frame(16, 1'b0, -1, 1'b1, 1'b0);
    wait_rxfull("promisc_unicast");
    do_ack();
`endif

    repeat (5) tick();
    check("exp_q_final", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #(50 * 95000);
    n_checks++;
    n_fail++;
    $display("FAIL timeout: got running expected finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
